// File: rtl/stack_sequencer.sv
// stack_sequencer: initiator side of the data-memory interface.
// Owns the 8-bit downward-growing stack pointer and sequences PUSH, POP,
// CALL and RET onto the data memory, one op at a time via valid/ready.
//
// Optional feature: define STACK_GUARD_EN to enable overflow/underflow
// guarding against SP_LIMIT / SP_INIT (fault pulse, write/load suppression).
// Without it, fault is tied 0 and SP wraps modulo 256.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   op_valid/op_code      stack op request (00 PUSH, 01 POP, 10 CALL, 11 RET)
//   op_ready              idle, able to accept an op
//   target_in             CALL destination, latched on accept
//   mem_rdata             asynchronous memory read data at current address
//   sp_out                stack pointer to memory SP input
//   wr, s2, s5            memory write enable, addr-mux (1=SP), data-mux (1=RN)
//   done                  one-cycle completion pulse
//   pop_data              value read by POP/RET, valid with done
//   rn_load, pc_load      register-file / PC load strobes, with done
//   pc_out                PC value: target for CALL, popped value for RET
//   fault                 one-cycle guard fault pulse, with done

module stack_sequencer #(
    parameter logic [7:0] SP_INIT  = 8'hFF,
    parameter logic [7:0] SP_LIMIT = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [1:0] op_code,
    output logic       op_ready,
    input  logic [7:0] target_in,
    input  logic [7:0] mem_rdata,
    output logic [7:0] sp_out,
    output logic       wr,
    output logic       s2,
    output logic       s5,
    output logic       done,
    output logic [7:0] pop_data,
    output logic       rn_load,
    output logic       pc_load,
    output logic [7:0] pc_out,
    output logic       fault
);

    localparam int unsigned W = 8;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

`ifdef STACK_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_INC   = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   sp_q, sp_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   tgt_q, tgt_d;
    logic [W-1:0]   pop_q, pop_d;
    logic [W-1:0]   pc_q, pc_d;
    logic           flt_q, flt_d;

    // Guard conditions; constant 0 when the guard is not built in
    logic push_block_c;
    logic pop_block_c;

    assign push_block_c = GUARD_EN && (sp_q < SP_LIMIT);
    assign pop_block_c  = GUARD_EN && (sp_q == SP_INIT);

    assign sp_out   = sp_q;
    assign pop_data = pop_q;
    assign pc_out   = pc_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sp_q    <= SP_INIT;
            op_q    <= OP_PUSH;
            tgt_q   <= '0;
            pop_q   <= '0;
            pc_q    <= '0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            pop_q   <= pop_d;
            pc_q    <= pc_d;
            flt_q   <= flt_d;
        end
    end

    // Next-state and output decode from state plus latched op
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        op_d     = op_q;
        tgt_d    = tgt_q;
        pop_d    = pop_q;
        pc_d     = pc_q;
        flt_d    = flt_q;
        op_ready = 1'b0;
        wr       = 1'b0;
        s2       = 1'b0;
        s5       = 1'b0;
        done     = 1'b0;
        rn_load  = 1'b0;
        pc_load  = 1'b0;
        fault    = 1'b0;

        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    op_d  = op_code;
                    tgt_d = target_in;
                    flt_d = 1'b0;
                    // bit 0 set for POP/RET: read path starts with pre-increment
                    state_d = op_code[0] ? S_INC : S_WRITE;
                end
            end

            S_WRITE: begin
                s2 = 1'b1;
                s5 = (op_q == OP_PUSH);
                if (push_block_c) begin
                    flt_d = 1'b1;
                end else begin
                    // A reset edge must never commit a write, even mid-op
                    wr   = !rst;
                    sp_d = sp_q - W'(1);
                end
                if (op_q == OP_CALL) begin
                    pc_d = tgt_q;
                end
                state_d = S_DONE;
            end

            S_INC: begin
                s2 = 1'b1;
                if (pop_block_c) begin
                    flt_d = 1'b1;
                end else begin
                    sp_d = sp_q + W'(1);
                end
                state_d = S_READ;
            end

            S_READ: begin
                s2    = 1'b1;
                pop_d = flt_q ? W'(0) : mem_rdata;
                if (op_q == OP_RET) begin
                    pc_d = flt_q ? W'(0) : mem_rdata;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                fault   = flt_q;
                rn_load = (op_q == OP_POP) && !flt_q;
                pc_load = ((op_q == OP_CALL) || (op_q == OP_RET)) && !flt_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Initiator side of the data-memory interface. Owns the 8-bit stack pointer and sequences PUSH, POP, CALL and RET onto the data memory.
- Drives the memory's SP address, write enable, address-select mux (S2) and data-select mux (S5). Consumes the memory's asynchronous read data.
- Sits between instruction decode and data memory. Decode issues one stack op at a time through a valid/ready handshake; when no stack op is active, the memory keeps using R0 addressing.

Parameters:
SP_INIT, 8'hFF, stack pointer value after reset; the stack is empty at this value; the stack grows downward.
SP_LIMIT, 8'h80, lowest writable stack address; used only when STACK_GUARD_EN is defined.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
op_valid  input  1  decode presents a stack op
op_code  input  2  00 PUSH, 01 POP, 10 CALL, 11 RET
op_ready  output  1  sequencer idle and able to accept an op
target_in  input  8  CALL destination; latched on accept
mem_rdata  input  8  memory read data (asynchronous read at the current address)
sp_out  output  8  stack pointer; drives the memory SP input
wr  output  1  memory write enable
s2  output  1  address-mux select: 1 = SP, 0 = R0
s5  output  1  data-mux select: 1 = RN, 0 = NPC
done  output  1  one-cycle pulse; op complete
pop_data  output  8  value read by POP/RET; valid while done=1
rn_load  output  1  pulses with done for POP; writes pop_data to RN
pc_load  output  1  pulses with done for CALL/RET
pc_out  output  8  PC value to load: target for CALL, pop_data for RET
fault  output  1  one-cycle guard fault pulse; tied 0 without STACK_GUARD_EN

Behaviour:
- Reset, applied at the edge where rst=1:
  - state=IDLE; sp_out=SP_INIT.
  - pop_data=0, pc_out=0.
  - done, rn_load, pc_load, fault all 0.
  - wr is combinationally gated by !rst, so no write occurs on any reset edge, including mid-op.
- States: IDLE, WRITE, INC, READ, DONE.
- IDLE:
  - op_ready=1, wr=0, s2=0.
  - Accept on op_valid&&op_ready; latch op_code and target_in.
  - PUSH/CALL go to WRITE; POP/RET go to INC.
- WRITE:
  - s2=1, wr=1; s5=1 for PUSH, 0 for CALL.
  - Memory writes mem[sp_out] at the edge that ends this cycle.
  - sp_out decrements at the same edge (post-decrement); next state DONE.
  - Caller holds RN and NPC stable from accept through this cycle.
- INC: s2=1, wr=0; sp_out<=sp_out+1 (pre-increment); next state READ.
- READ: s2=1, wr=0; pop_data<=mem_rdata; for RET also pc_out<=mem_rdata; next state DONE.
- DONE:
  - done=1 for one cycle.
  - rn_load=1 for POP; pc_load=1 for CALL/RET; pc_out=target for CALL.
  - s2=0; next state IDLE.
- op_ready=0 in every state except IDLE. op_valid is ignored while busy, and no op is queued.
- Latency, accept edge to done high: PUSH/CALL 2 cycles; POP/RET 3 cycles. Back-to-back ops are possible one cycle after done.
- Arithmetic: sp_out is modulo 256.
- Without the guard:
  - PUSH at SP=8'h00 writes address 00 and wraps SP to FF.
  - POP at SP=FF wraps SP to 00 and reads mem[00].
- Outputs are decoded from state plus latched registers. There are no combinational paths from op_valid to wr, s2 or s5.

Optional Feature:
Macro: STACK_GUARD_EN.
- When defined:
  - In WRITE, if sp_out<SP_LIMIT: wr forced 0, SP unchanged, fault=1 in DONE.
  - In INC, if sp_out==SP_INIT: SP unchanged, the READ state is still visited, pop_data=0, fault=1 in DONE.
  - On any fault, rn_load and pc_load are suppressed; done still pulses.
- When undefined: fault is tied 0 and wrap-around is as described under Behaviour.

Test Plan:
- Reset, then idle → sp_out=FF, wr=0, s2=0, op_ready=1, done=0.
- PUSH with RN=8'h5A → WRITE cycle shows wr=1, s2=1, s5=1, sp_out=FF; mem[FF]=5A; done 2 cycles after accept; sp_out=FE.
- CALL target=8'h40, NPC=8'h12, then RET → mem[FF]=12, pc_out=40 with pc_load; the RET's done has pc_out=12, pc_load=1, sp_out=FF, latency 3.
- PUSH A5, PUSH 3C, POP, POP → pop_data 3C then A5 with rn_load; final sp_out=FF.
- rst asserted during a PUSH WRITE cycle → no memory write; next cycle sp_out=FF, state IDLE, done=0.
- With STACK_GUARD_EN and SP_LIMIT=FE: three PUSHes, then POP on an empty stack → third PUSH has no wr, fault=1, sp_out stays FD; POP on empty has fault=1, pop_data=0, no rn_load.
